act_lut_loader: RTL and testbench

- Writable activation-function lookup table for the NN datapath. It sits between the host-side weight and parameter stream and each layer's activation unit.
- Loads DEPTH signed entries through a valid/ready stream, then serves interpolation reads.
- Each read returns a base value and a next value, using the same neighbour/wrap rule as the fixed activation LUTs.

---
 rtl/act_lut_pkg.sv | 27 ++
 rtl/act_lut_regfile.sv | 35 +++
 rtl/act_lut_loader.sv | 114 +++++++++++
 tb/tb_act_lut_loader.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/act_lut_pkg.sv
// Shared types and helpers for the activation lookup tables (loadable and fixed variants).
package act_lut_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int IDX_W      = 16;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  // Interpolation neighbour, with the address read as two's complement of width addr_w:
  // all-ones wraps to 0, the positive maximum saturates onto itself, anything else steps by one.
  function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] addr, input int addr_w);
    logic [IDX_W-1:0] mask;
    logic [IDX_W-1:0] pos_max;
    logic [IDX_W-1:0] a;
    mask    = (IDX_W'(1) << addr_w) - IDX_W'(1);
    pos_max = mask >> 1;
    a       = addr & mask;
    if (a == mask)
      next_index = '0;
    else if (a == pos_max)
      next_index = a;
    else
      next_index = (a + IDX_W'(1)) & mask;
  endfunction

endpackage

// File: rtl/act_lut_regfile.sv
// DEPTH x DATA_W table with one write port and two combinational read indices.
module act_lut_regfile
  import act_lut_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic signed [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0]        raddr_a,
  input  logic [ADDR_W-1:0]        raddr_b,
  output logic signed [DATA_W-1:0] rdata_a,
  output logic signed [DATA_W-1:0] rdata_b
);

  localparam int DEPTH = 1 << ADDR_W;

  logic signed [DATA_W-1:0] mem [DEPTH];

  // Reads see the array before this cycle's write lands (read-before-write).
  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/act_lut_loader.sv
// Stream-loaded activation LUT: fills DEPTH entries in order, then serves base/neighbour reads.
module act_lut_loader
  import act_lut_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic [ADDR_W:0]          wr_count,
  output logic                     busy,
  output logic                     loaded,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        address,
  output logic signed [DATA_W-1:0] base,
  output logic signed [DATA_W-1:0] next_data,
  output logic                     rd_valid
);

  localparam int              DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST  = (ADDR_W + 1)'(DEPTH - 1);

  state_t                   state;
  logic                     accept;
  logic [ADDR_W-1:0]        nb_idx_p0;
  logic signed [DATA_W-1:0] base_p0;
  logic signed [DATA_W-1:0] next_p0;
  logic signed [DATA_W-1:0] base_p1;
  logic signed [DATA_W-1:0] next_p1;
  logic                     vld_p1;

  // A word offered alongside start belongs to no load and is dropped.
  assign accept    = in_valid & in_ready & ~start;
  assign nb_idx_p0 = ADDR_W'(next_index(IDX_W'(address), ADDR_W));

  act_lut_regfile #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (accept),
    .waddr  (wr_count[ADDR_W-1:0]),
    .wdata  (in_data),
    .raddr_a(address),
    .raddr_b(nb_idx_p0),
    .rdata_a(base_p0),
    .rdata_b(next_p0)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      loaded   <= 1'b0;
      wr_count <= '0;
    end else if (start) begin
      state    <= LOAD;
      in_ready <= 1'b1;
      busy     <= 1'b1;
      loaded   <= 1'b0;
      wr_count <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            wr_count <= wr_count + 1'b1;
            if (wr_count == LAST) begin
              state    <= DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              loaded   <= 1'b1;
            end
          end
        end
        IDLE, DONE: begin
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          loaded   <= 1'b0;
        end
      endcase
    end
  end

  // ---- p0 -> p1: registered read; data holds whenever no valid read occurs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      base_p1 <= '0;
      next_p1 <= '0;
    end else begin
      vld_p1 <= rd_en & loaded;
      if (rd_en & loaded) begin
        base_p1 <= base_p0;
        next_p1 <= next_p0;
      end
    end
  end

  assign base      = base_p1;
  assign next_data = next_p1;
  assign rd_valid  = vld_p1;

endmodule

// File: tb/tb_act_lut_loader.sv
// Directed bench for act_lut_loader with a queue-based read scoreboard.
module tb_act_lut_loader;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] in_data;
  logic [4:0]        wr_count;
  logic              busy;
  logic              loaded;
  logic              rd_en;
  logic [3:0]        address;
  logic signed [7:0] base;
  logic signed [7:0] next_data;
  logic              rd_valid;

  typedef struct packed {
    logic signed [7:0] b;
    logic signed [7:0] n;
  } exp_t;

  exp_t              sb[$];
  logic signed [7:0] stim [16];
  int                n_pass = 0;
  int                n_total = 0;

  act_lut_loader #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .wr_count (wr_count),
    .busy     (busy),
    .loaded   (loaded),
    .rd_en    (rd_en),
    .address  (address),
    .base     (base),
    .next_data(next_data),
    .rd_valid (rd_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Streams stim[0..n-1]; with gap set, in_valid drops every other cycle carrying junk data.
  task automatic load_words(input int n, input bit gap);
    int i;
    bit idle;
    i = 0;
    idle = 1'b0;
    while (i < n) begin
      if (gap && idle) begin
        in_valid = 1'b0;
        in_data  = 8'sh55;
      end else begin
        in_valid = 1'b1;
        in_data  = stim[i];
        if (in_ready !== 1'b1) chk("in_ready_during_load", int'(in_ready), 1);
        i++;
      end
      idle = ~idle;
      tick();
    end
    in_valid = 1'b0;
    if (n == 16) begin
      chk("loaded_after_last", int'(loaded), 1);
      chk("wr_count_full", int'(wr_count), 16);
      chk("in_ready_done", int'(in_ready), 0);
      chk("busy_done", int'(busy), 0);
    end
  endtask

  task automatic rd(input int a, input int eb, input int en);
    exp_t e;
    e.b = 8'(eb);
    e.n = 8'(en);
    sb.push_back(e);
    rd_en   = 1'b1;
    address = 4'(a);
    tick();
    rd_en = 1'b0;
  endtask

  function automatic int nb(input int a);
    if (a == 15) return 0;
    if (a == 7)  return 7;
    return a + 1;
  endfunction

  // Scoreboard monitor: every presented read is matched against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rd_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_rd_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("base", int'(base), int'(e.b));
          chk("next_data", int'(next_data), int'(e.n));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; rd_en = 1'b0; address = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_wr_count", int'(wr_count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_loaded", int'(loaded), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    // IDLE ignores in_valid
    in_valid = 1'b1; in_data = 8'sd99;
    tick();
    in_valid = 1'b0;
    chk("idle_ignores_valid", int'(wr_count), 0);

    // Load 0,16,...,112 then eight zeros
    for (int i = 0; i < 16; i++) stim[i] = (i < 8) ? 8'(i * 16) : 8'sd0;
    do_start();
    chk("busy_in_load", int'(busy), 1);
    load_words(16, 1'b0);
    rd(3, 48, 64);
    rd(7, 112, 112);
    rd(15, 0, 0);
    rd(6, 96, 112);
    rd(8, 0, 0);
    tick();

    // Reload with entry0=-5, entry15=9
    for (int i = 0; i < 16; i++) stim[i] = 8'(i);
    stim[0] = -8'sd5; stim[15] = 8'sd9;
    do_start();
    load_words(16, 1'b0);
    rd(15, 9, -5);
    rd(7, 7, 7);
    rd(0, -5, 1);
    tick();

    // Gapped stream: only handshaked words land, in order
    for (int i = 0; i < 16; i++) stim[i] = 8'(-64 + 9 * i);
    do_start();
    load_words(16, 1'b1);
    for (int a = 0; a < 16; a++) rd(a, int'(stim[a]), int'(stim[nb(a)]));
    tick();

    // Restart after 5 words; start cycle word is dropped; reads during LOAD are invalid
    for (int i = 0; i < 16; i++) stim[i] = 8'(100 + i);
    do_start();
    load_words(5, 1'b0);
    chk("wr_count_partial", int'(wr_count), 5);
    rd_en = 1'b1; address = 4'd2;
    tick();
    rd_en = 1'b0;
    chk("rd_valid_in_load", int'(rd_valid), 0);
    start = 1'b1; in_valid = 1'b1; in_data = 8'sh77;
    tick();
    start = 1'b0; in_valid = 1'b0;
    chk("restart_wr_count", int'(wr_count), 0);
    chk("restart_loaded", int'(loaded), 0);
    chk("restart_busy", int'(busy), 1);
    for (int i = 0; i < 16; i++) stim[i] = 8'(20 + i);
    load_words(16, 1'b0);
    rd(0, 20, 21);
    rd(4, 24, 25);
    tick();

    // Reset mid-load
    do_start();
    load_words(3, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_wr_count", int'(wr_count), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_loaded", int'(loaded), 0);
    chk("midrst_base", int'(base), 0);
    chk("midrst_next", int'(next_data), 0);
    chk("midrst_rd_valid", int'(rd_valid), 0);
    for (int i = 0; i < 16; i++) stim[i] = -8'sd1;
    do_start();
    load_words(16, 1'b0);
    rd(5, -1, -1);
    rd(15, -1, -1);
    rd(7, -1, -1);
    tick(); tick();

    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
